// File: rtl/ard_bus_bridge.sv
// ard_bus_bridge
//   Bridges the core's word-wide memory request port onto the narrow,
//   externally clocked microcontroller bus. A request is sent as address
//   beats and then data beats of BUS_W bits, least-significant beat first.
//   Every beat carries a PC/MAR/MDR tag. Beats advance only on synchronised
//   rising edges of ard_clk, qualified by the external ready handshakes.
//   Read beats are assembled into a word and returned as a one-cycle response.
//
// Ports
//   clock, reset         : single clock, synchronous active-high reset
//   req_valid/req_ready  : request handshake (ready only while idle)
//   req_write, req_fetch : write/read select, PC/MAR tag select for address
//   req_addr, req_wdata  : request address and write data
//   rsp_valid, rsp_rdata : one-cycle completion pulse, last read word
//   ard_clk              : asynchronous beat clock from the external side
//   ard_data_ready       : external side drives a valid read beat on in_bus
//   ard_receive_ready    : external side takes the beat on out_bus
//   in_bus, out_bus      : read beat in, address/write beat out (registered)
//   bus_pc/mar/mdr       : registered beat tags, one-hot or all zero
`timescale 1ns/1ps

module ard_bus_bridge #(
    parameter int BUS_W  = 8,
    parameter int WORD_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_fetch,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    input  logic              ard_clk,
    input  logic              ard_data_ready,
    input  logic              ard_receive_ready,
    input  logic [BUS_W-1:0]  in_bus,
    output logic [BUS_W-1:0]  out_bus,
    output logic              bus_pc,
    output logic              bus_mar,
    output logic              bus_mdr
);

    localparam int ADDR_BEATS = ADDR_W / BUS_W;
    localparam int WORD_BEATS = WORD_W / BUS_W;
    localparam int MAX_BEATS  = (ADDR_BEATS > WORD_BEATS) ? ADDR_BEATS : WORD_BEATS;
    localparam int CNT_W      = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BEATS - 1);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORD_BEATS - 1);

    if ((WORD_W % BUS_W) != 0) begin : g_bad_word_w
        $error("ard_bus_bridge: WORD_W must be a multiple of BUS_W");
    end
    if ((ADDR_W % BUS_W) != 0) begin : g_bad_addr_w
        $error("ard_bus_bridge: ADDR_W must be a multiple of BUS_W");
    end

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, RDATA, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W-1:0]  addr_q;
    logic [WORD_W-1:0]  wdata_q;
    logic               write_q;
    logic [WORD_W-1:0]  rd_buf;
    logic [WORD_W-1:0]  rd_next;

    // All external inputs share one two-flop chain so they stay aligned;
    // ard_clk gets a third flop for rising-edge detection.
    logic               ard_clk_p1, ard_clk_p2, ard_clk_p3;
    logic               drdy_p1, drdy_p2;
    logic               rrdy_p1, rrdy_p2;
    logic [BUS_W-1:0]   in_bus_p1, in_bus_p2;
    logic               tick;

    // Synchroniser stage p1 -> p2 (-> p3 for ard_clk)
    always_ff @(posedge clock) begin
        if (reset) begin
            ard_clk_p1 <= 1'b0;
            ard_clk_p2 <= 1'b0;
            ard_clk_p3 <= 1'b0;
            drdy_p1    <= 1'b0;
            drdy_p2    <= 1'b0;
            rrdy_p1    <= 1'b0;
            rrdy_p2    <= 1'b0;
            in_bus_p1  <= '0;
            in_bus_p2  <= '0;
        end else begin
            ard_clk_p1 <= ard_clk;
            ard_clk_p2 <= ard_clk_p1;
            ard_clk_p3 <= ard_clk_p2;
            drdy_p1    <= ard_data_ready;
            drdy_p2    <= drdy_p1;
            rrdy_p1    <= ard_receive_ready;
            rrdy_p2    <= rrdy_p1;
            in_bus_p1  <= in_bus;
            in_bus_p2  <= in_bus_p1;
        end
    end

    assign tick      = ard_clk_p2 & ~ard_clk_p3;
    assign req_ready = (state == IDLE);

    // Read word with the current beat dropped into its slot, so the final
    // beat can be forwarded straight to rsp_rdata.
    always_comb begin
        rd_next = rd_buf;
        rd_next[int'(cnt)*BUS_W +: BUS_W] = in_bus_p2;
    end

    // Transfer FSM stage: outputs are registered on the edge that enters a
    // state or advances the beat counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            rd_buf    <= '0;
            out_bus   <= '0;
            bus_pc    <= 1'b0;
            bus_mar   <= 1'b0;
            bus_mdr   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state   <= ADDR;
                        cnt     <= '0;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        write_q <= req_write;
                        out_bus <= req_addr[BUS_W-1:0];
                        bus_pc  <= req_fetch;
                        bus_mar <= ~req_fetch;
                        bus_mdr <= 1'b0;
                    end
                end
                ADDR: begin
                    if (tick && rrdy_p2) begin
                        if (cnt == ADDR_LAST) begin
                            cnt     <= '0;
                            bus_pc  <= 1'b0;
                            bus_mar <= 1'b0;
                            bus_mdr <= 1'b1;
                            if (write_q) begin
                                state   <= WDATA;
                                out_bus <= wdata_q[BUS_W-1:0];
                            end else begin
                                state   <= RDATA;
                                out_bus <= '0;
                            end
                        end else begin
                            cnt     <= cnt + 1'b1;
                            out_bus <= addr_q[(int'(cnt)+1)*BUS_W +: BUS_W];
                        end
                    end
                end
                WDATA: begin
                    if (tick && rrdy_p2) begin
                        if (cnt == WORD_LAST) begin
                            state     <= DONE;
                            cnt       <= '0;
                            out_bus   <= '0;
                            bus_mdr   <= 1'b0;
                            rsp_valid <= 1'b1;
                        end else begin
                            cnt     <= cnt + 1'b1;
                            out_bus <= wdata_q[(int'(cnt)+1)*BUS_W +: BUS_W];
                        end
                    end
                end
                RDATA: begin
                    if (tick && drdy_p2) begin
                        rd_buf <= rd_next;
                        if (cnt == WORD_LAST) begin
                            state     <= DONE;
                            cnt       <= '0;
                            bus_mdr   <= 1'b0;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= rd_next;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ard_bus_bridge.sv
`timescale 1ns/1ps

module tb_ard_bus_bridge;

    localparam int BW   = 8;
    localparam int WW   = 16;
    localparam int AW   = 16;
    localparam int AB   = AW / BW;
    localparam int DB   = WW / BW;
    localparam int HALF = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0, req_write = 1'b0, req_fetch = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [WW-1:0] req_wdata = '0;
    logic          req_ready, rsp_valid;
    logic [WW-1:0] rsp_rdata;
    logic          ard_clk = 1'b0, dr = 1'b1, rr = 1'b1;
    logic [BW-1:0] in_bus = '0;
    logic [BW-1:0] out_bus;
    logic          bus_pc, bus_mar, bus_mdr;

    // Narrow-bus instance (BUS_W = 4)
    logic          req4_valid = 1'b0;
    logic          req4_ready, rsp4_valid, pc4, mar4, mdr4;
    logic [WW-1:0] rsp4_rdata;
    logic [3:0]    out4;
    logic          one4 = 1'b1;
    logic [3:0]    in4 = 4'h0;
    int            rsp4_cnt = 0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [BW-1:0] val;
        logic [2:0]    tag;   // {pc, mar, mdr}
    } beat_t;

    beat_t         exp_beats[$];
    logic [WW-1:0] exp_rsp[$];
    logic [WW-1:0] ref_mem [logic [AW-1:0]];
    logic [WW-1:0] dev_mem [logic [AW-1:0]];
    logic [WW-1:0] last_rd = '0;
    logic          cur_write = 1'b0;
    int            stall_req = 0;
    bit            rand_mode = 1'b0;
    int            addr_idx = 0, dat_idx = 0;
    logic [AW-1:0] dev_addr = '0;
    logic [WW-1:0] dev_wdata = '0;

    ard_bus_bridge #(.BUS_W(BW), .WORD_W(WW), .ADDR_W(AW)) u_dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_fetch(req_fetch), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ard_clk(ard_clk), .ard_data_ready(dr), .ard_receive_ready(rr),
        .in_bus(in_bus), .out_bus(out_bus),
        .bus_pc(bus_pc), .bus_mar(bus_mar), .bus_mdr(bus_mdr)
    );

    ard_bus_bridge #(.BUS_W(4), .WORD_W(16), .ADDR_W(16)) u_dut4 (
        .clock(clock), .reset(reset),
        .req_valid(req4_valid), .req_ready(req4_ready), .req_write(1'b1),
        .req_fetch(1'b0), .req_addr(16'h0000), .req_wdata(16'hBEEF),
        .rsp_valid(rsp4_valid), .rsp_rdata(rsp4_rdata),
        .ard_clk(ard_clk), .ard_data_ready(one4), .ard_receive_ready(one4),
        .in_bus(in4), .out_bus(out4),
        .bus_pc(pc4), .bus_mar(mar4), .bus_mdr(mdr4)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WW-1:0] dflt(input logic [AW-1:0] a);
        return a ^ 16'hC35A;
    endfunction

    function automatic logic [WW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic logic [WW-1:0] dev_read(input logic [AW-1:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : dflt(a);
    endfunction

    // External device: samples the offered beat on each ard_clk rise.
    task automatic bfm_rise();
        logic [2:0] tag;
        bit         consumed;
        tag = {bus_pc, bus_mar, bus_mdr};
        if (reset || tag == 3'b000) begin
            addr_idx = 0;
            dat_idx  = 0;
            return;
        end
        consumed = bus_mdr ? (cur_write ? rr : dr) : rr;
        if (exp_beats.size() == 0) begin
            check("beat_unexpected_tag", 32'(tag), 32'(0));
            return;
        end
        check(consumed ? "beat_val" : "hold_val", 32'(out_bus), 32'(exp_beats[0].val));
        check(consumed ? "beat_tag" : "hold_tag", 32'(tag), 32'(exp_beats[0].tag));
        if (consumed) begin
            void'(exp_beats.pop_front());
            if (!bus_mdr) begin
                dev_addr[addr_idx*BW +: BW] = out_bus;
                addr_idx++;
            end else if (cur_write) begin
                dev_wdata[dat_idx*BW +: BW] = out_bus;
                dat_idx++;
                if (dat_idx == DB) dev_mem[dev_addr] = dev_wdata;
            end else begin
                dat_idx++;
            end
        end
    endtask

    // External device: updates handshakes and read beat on each ard_clk fall.
    task automatic bfm_fall();
        logic [WW-1:0] w;
        if (rand_mode) begin
            rr = ($urandom % 4) != 0;
            dr = ($urandom % 4) != 0;
        end else begin
            rr = 1'b1;
            dr = 1'b1;
        end
        if (stall_req > 0 && (bus_pc || bus_mar) && addr_idx == 1) begin
            rr = 1'b0;
            stall_req--;
        end
        if (bus_mdr && !cur_write && dat_idx < DB) begin
            w = dev_read(dev_addr);
            in_bus = w[dat_idx*BW +: BW];
        end else begin
            in_bus = BW'($urandom);
        end
    endtask

    initial begin
        forever begin
            repeat (HALF) @(negedge clock);
            ard_clk = 1'b1;
            bfm_rise();
            repeat (HALF) @(negedge clock);
            ard_clk = 1'b0;
            bfm_fall();
        end
    end

    // Response monitor / scoreboard
    initial begin
        logic [WW-1:0] e;
        forever begin
            @(negedge clock);
            if (!reset && rsp_valid) begin
                check("rsp_with_ready", 32'(req_ready), 32'(0));
                if (exp_rsp.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'(0));
                end else begin
                    e = exp_rsp.pop_front();
                    check("rsp_rdata", 32'(rsp_rdata), 32'(e));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (rsp4_valid) rsp4_cnt++;
        end
    end

    task automatic issue(input logic wr, input logic fetch, input logic [AW-1:0] addr,
                         input logic [WW-1:0] wdata);
        logic [WW-1:0] e;
        for (int k = 0; k < AB; k++)
            exp_beats.push_back('{BW'(addr >> (k*BW)), fetch ? 3'b100 : 3'b010});
        for (int k = 0; k < DB; k++)
            exp_beats.push_back('{wr ? BW'(wdata >> (k*BW)) : BW'(0), 3'b001});
        if (wr) begin
            ref_mem[addr] = wdata;
            exp_rsp.push_back(last_rd);
        end else begin
            e = ref_read(addr);
            last_rd = e;
            exp_rsp.push_back(e);
        end
        @(negedge ard_clk);
        check("ready_before_req", 32'(req_ready), 32'(1));
        cur_write = wr;
        req_write = wr;
        req_fetch = fetch;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        check("ready_after_accept", 32'(req_ready), 32'(0));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_rsp.size() != 0 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (exp_rsp.size() != 0) begin
            check("rsp_timeout", 32'(exp_rsp.size()), 32'(0));
            exp_rsp.delete();
            exp_beats.delete();
        end else begin
            check("beats_left", 32'(exp_beats.size()), 32'(0));
        end
        @(negedge clock);
    endtask

    initial begin
        #400us;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] pool [6];
        beat_t         got4[$];
        logic [3:0]    exp4_val [8];
        logic [2:0]    exp4_tag [8];
        int            n;

        // Reset held while ard_clk toggles
        reset = 1'b1;
        repeat (10) begin
            @(negedge clock);
            check("rst_out_bus", 32'(out_bus), 32'(0));
            check("rst_tags", 32'({bus_pc, bus_mar, bus_mdr}), 32'(0));
        end
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_ready", 32'(req_ready), 32'(1));
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("post_rst_rdata", 32'(rsp_rdata), 32'(0));
        check("post_rst_out_bus", 32'(out_bus), 32'(0));

        // Plain write
        issue(1'b1, 1'b0, 16'h1234, 16'hBEEF);
        wait_done();

        // Fetch read
        ref_mem[16'h00A0] = 16'h2211;
        dev_mem[16'h00A0] = 16'h2211;
        issue(1'b0, 1'b1, 16'h00A0, 16'h0000);
        wait_done();
        check("fetch_read_word", 32'(rsp_rdata), 32'(16'h2211));

        // Stall on the second address beat
        stall_req = 3;
        issue(1'b1, 1'b0, 16'h1234, 16'h0F0F);
        wait_done();
        check("stall_consumed", 32'(stall_req), 32'(0));
        check("write_keeps_rdata", 32'(rsp_rdata), 32'(16'h2211));

        // Reset after the first read data beat
        ref_mem[16'h0042] = 16'hABCD;
        dev_mem[16'h0042] = 16'hABCD;
        issue(1'b0, 1'b0, 16'h0042, 16'h0000);
        n = 0;
        while (dat_idx != 1 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check("abort_reached_beat", 32'(dat_idx), 32'(1));
        repeat (4) @(negedge clock);
        reset = 1'b1;
        exp_rsp.delete();
        exp_beats.delete();
        last_rd = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("abort_ready", 32'(req_ready), 32'(1));
        check("abort_rdata", 32'(rsp_rdata), 32'(0));
        check("abort_tags", 32'({bus_pc, bus_mar, bus_mdr}), 32'(0));
        repeat (30) @(negedge clock);

        ref_mem[16'h0077] = 16'h5566;
        dev_mem[16'h0077] = 16'h5566;
        issue(1'b0, 1'b0, 16'h0077, 16'h0000);
        wait_done();
        check("read_after_abort", 32'(rsp_rdata), 32'(16'h5566));

        // Randomised traffic with random handshake stalls
        for (int i = 0; i < 6; i++) pool[i] = AW'($urandom);
        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            issue(1'($urandom), 1'($urandom), pool[$urandom % 6], WW'($urandom));
            wait_done();
        end
        rand_mode = 1'b0;
        repeat (2 * HALF) @(negedge clock);

        // BUS_W = 4 instance: write 0xBEEF to 0x0000
        exp4_val = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hE, 4'hE, 4'hB};
        exp4_tag = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b001, 3'b001, 3'b001, 3'b001};
        rsp4_cnt = 0;
        @(negedge ard_clk);
        req4_valid = 1'b1;
        @(negedge clock);
        req4_valid = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(posedge ard_clk);
            if ({pc4, mar4, mdr4} != 3'b000)
                got4.push_back('{BW'(out4), {pc4, mar4, mdr4}});
        end
        repeat (4) @(negedge clock);
        check("bus4_beat_count", 32'(got4.size()), 32'(8));
        for (int i = 0; i < 8; i++) begin
            if (i < got4.size()) begin
                check("bus4_beat_val", 32'(got4[i].val), 32'(exp4_val[i]));
                check("bus4_beat_tag", 32'(got4[i].tag), 32'(exp4_tag[i]));
            end
        end
        check("bus4_rsp_count", 32'(rsp4_cnt), 32'(1));
        check("bus4_rdata_kept", 32'(rsp4_rdata), 32'(0));
        check("bus4_ready", 32'(req4_ready), 32'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
